screen_fill_writer: RTL and testbench
=====================================

// Module: screen_fill_writer
// PURPOSE
//  Write side of the 10x10 screen memory. Owns the screen array (12-bit RGB, [11:8]=R, [7:4]=G, [3:0]=B).
//  Accepts rectangle-fill commands over a valid/ready handshake and writes one cell per clk_d cycle in raster order.
//  Provides a registered read port addressed by (x_loc, y_loc) for the pixel/colour stage on the display side.
//  Replaces the initial-block preload; every screen update at run time goes through this block.
// PARAMETERS
//  COLS   10  screen width in cells (x range 0..COLS-1)
//  ROWS   10  screen height in cells (y range 0..ROWS-1)
//  CW     12  colour word width
//  AW     10  coordinate width; matches x_loc/y_loc
// PORTS
//  clk_d      in   1    pixel clock; single clock domain
//  reset      in   1    asynchronous, active-high
//  cmd_valid  in   1    fill command present
//  cmd_ready  out  1    block can accept a command (high only in IDLE)
//  cmd_x0     in   AW   left column, inclusive
//  cmd_y0     in   AW   top row, inclusive
//  cmd_x1     in   AW   right column, inclusive
//  cmd_y1     in   AW   bottom row, inclusive
//  cmd_color  in   CW   fill colour
//  busy       out  1    high in FILL and DONE
//  done       out  1    1-cycle pulse after the last write of an accepted command
//  err        out  1    1-cycle pulse when a rejected command was handshaken
//  x_loc      in   AW   read column
//  y_loc      in   AW   read row
//  rd_color   out  CW   registered colour of screen[x_loc][y_loc]
// BEHAVIOUR
//  Reset (async, active-high): state=IDLE; busy=0, done=0, err=0, rd_color=0; cmd_ready=1 once reset drops.
//   Memory is NOT cleared by reset. Contents are undefined until written.
//  Handshake: transfer when cmd_valid && cmd_ready at a rising clk_d edge. cmd_* are sampled only at that edge.
//  Validation at accept: x0<=x1, y0<=y1, x1<COLS, y1<ROWS.
//   On failure: err=1 for the next cycle; no writes; stay IDLE.
//   On success: latch x0,x1,y1,color; cur_x=x0, cur_y=y0; go to FILL.
//  FILL: each edge writes screen[cur_x][cur_y]=color, then:
//   if cur_x!=x1: cur_x++.
//   else if cur_y!=y1: cur_x=x0, cur_y++.
//   else: go to DONE.
//   Write count = (x1-x0+1)*(y1-y0+1). Command accepted at edge N -> writes at edges N+1..N+K.
//  DONE: done=1 for exactly one cycle (the cycle after edge N+K); next edge returns to IDLE.
//   cmd_ready=0 in FILL and DONE; cmd_valid in those states is ignored, not queued.
//  Read port: rd_color <= screen[x_loc][y_loc] at every edge (1-cycle latency), independent of state.
//   Out-of-range x_loc>=COLS or y_loc>=ROWS -> rd_color <= 0.
//   Read and write of the same cell on the same edge returns the OLD value.
//  Widths: coordinate compares are unsigned AW-bit; no wrap (validation guarantees x1<COLS, y1<ROWS).
//  Reset mid-FILL: aborts immediately. Cells already written keep the new colour; the rest are unchanged.
//   No done or err pulse is produced.
// TESTING
//  1 reset; fill (0,0)-(9,9) colour 12'h801 -> 100 write cycles, done pulses once 101 cycles after accept;
//    read every cell -> 12'h801.
//  2 fill (3,4)-(3,4) colour 12'hFFF -> one write, done on 2nd cycle after accept; rd (3,4)=FFF;
//    (2,4),(4,4),(3,3),(3,5) unchanged.
//  3 cmd x0=5,x1=2 -> err high 1 cycle, done never, cmd_ready stays 1, memory unchanged.
//  4 cmd x1=10 (COLS) -> err; then x_loc=12,y_loc=0 -> rd_color=12'h000 one cycle later.
//  5 hold cmd_valid with 2nd cmd during a fill of (0,0)-(1,1) -> ready=0 for 5 cycles;
//    2nd cmd accepted on the first IDLE edge; both regions correct.
//  6 fill (0,0)-(9,9) colour 12'h555 over a pre-filled 12'h000 screen; assert reset after 25 writes ->
//    rows y=0,1 and (0..4,2) hold 555, all else 000; busy=0, done=0.

Source files
------------

// File: rtl/screen_fill_writer.sv
// rtl/screen_fill_writer.sv - screen memory write side: rectangle fill engine plus registered read port
module screen_fill_writer #(
    parameter int COLS = 10,
    parameter int ROWS = 10,
    parameter int CW   = 12,
    parameter int AW   = 10
) (
    input  logic          clk_d,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_x0,
    input  logic [AW-1:0] cmd_y0,
    input  logic [AW-1:0] cmd_x1,
    input  logic [AW-1:0] cmd_y1,
    input  logic [CW-1:0] cmd_color,
    output logic          busy,
    output logic          done,
    output logic          err,
    input  logic [AW-1:0] x_loc,
    input  logic [AW-1:0] y_loc,
    output logic [CW-1:0] rd_color
);

    localparam int XW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int YW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [AW-1:0] cur_x;
    logic [AW-1:0] cur_y;
    logic [AW-1:0] x0_q;
    logic [AW-1:0] x1_q;
    logic [AW-1:0] y1_q;
    logic [CW-1:0] color_q;

    logic          cmd_ok;
    logic          start;
    logic          reject;
    logic          wr_en;
    logic          rd_in_range;

    logic [CW-1:0] screen [COLS][ROWS];

    // A command is only legal if it is a non-empty rectangle fully on screen.
    assign cmd_ok = (cmd_x0 <= cmd_x1) && (cmd_y0 <= cmd_y1) &&
                    (cmd_x1 < AW'(COLS)) && (cmd_y1 < AW'(ROWS));

    assign rd_in_range = (x_loc < AW'(COLS)) && (y_loc < AW'(ROWS));

    // State register.
    always_ff @(posedge clk_d or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake/status decode; commands arriving outside IDLE are dropped.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        wr_en     = 1'b0;
        start     = 1'b0;
        reject    = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = !reset;
                if (cmd_valid && !reset) begin
                    if (cmd_ok) begin
                        start     = 1'b1;
                        state_nxt = FILL;
                    end else begin
                        reject    = 1'b1;
                    end
                end
            end
            FILL: begin
                busy  = 1'b1;
                wr_en = 1'b1;
                if ((cur_x == x1_q) && (cur_y == y1_q)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Command latch, raster cursor and one-cycle error pulse.
    always_ff @(posedge clk_d or posedge reset) begin
        if (reset) begin
            cur_x   <= '0;
            cur_y   <= '0;
            x0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            color_q <= '0;
            err     <= 1'b0;
        end else begin
            err <= reject;
            if (start) begin
                cur_x   <= cmd_x0;
                cur_y   <= cmd_y0;
                x0_q    <= cmd_x0;
                x1_q    <= cmd_x1;
                y1_q    <= cmd_y1;
                color_q <= cmd_color;
            end else if (wr_en) begin
                if (cur_x != x1_q) begin
                    cur_x <= cur_x + AW'(1);
                end else if (cur_y != y1_q) begin
                    cur_x <= x0_q;
                    cur_y <= cur_y + AW'(1);
                end
            end
        end
    end

    // Screen array write; contents deliberately survive reset.
    always_ff @(posedge clk_d) begin
        if (wr_en) begin
            screen[cur_x[XW-1:0]][cur_y[YW-1:0]] <= color_q;
        end
    end

    // Registered read port; a same-edge write is not forwarded, so the old value is returned.
    always_ff @(posedge clk_d or posedge reset) begin
        if (reset) begin
            rd_color <= '0;
        end else if (rd_in_range) begin
            rd_color <= screen[x_loc[XW-1:0]][y_loc[YW-1:0]];
        end else begin
            rd_color <= '0;
        end
    end

endmodule

// File: tb/tb_screen_fill_writer.sv
// tb/tb_screen_fill_writer.sv - directed-vector bench for screen_fill_writer
module tb_screen_fill_writer;

    logic        clk_d = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_x0 = '0;
    logic [9:0]  cmd_y0 = '0;
    logic [9:0]  cmd_x1 = '0;
    logic [9:0]  cmd_y1 = '0;
    logic [11:0] cmd_color = '0;
    logic        busy;
    logic        done;
    logic        err;
    logic [9:0]  x_loc = '0;
    logic [9:0]  y_loc = '0;
    logic [11:0] rd_color;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [11:0] model [10][10];

    screen_fill_writer dut (
        .clk_d     (clk_d),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x0    (cmd_x0),
        .cmd_y0    (cmd_y0),
        .cmd_x1    (cmd_x1),
        .cmd_y1    (cmd_y1),
        .cmd_color (cmd_color),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .x_loc     (x_loc),
        .y_loc     (y_loc),
        .rd_color  (rd_color)
    );

    always #5 clk_d = ~clk_d;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_fill(input int x0, input int y0, input int x1, input int y1,
                              input logic [11:0] c);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                model[x][y] = c;
    endtask

    // Drive a command at the negedge and hold it until the edge that accepts it.
    task automatic send_cmd(input int x0, input int y0, input int x1, input int y1,
                            input logic [11:0] c);
        bit ok;
        ok = 0;
        @(negedge clk_d);
        cmd_x0 = 10'(x0); cmd_y0 = 10'(y0); cmd_x1 = 10'(x1); cmd_y1 = 10'(y1);
        cmd_color = c;
        cmd_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (cmd_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk_d);
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk_d);
        #1 cmd_valid = 1'b0;
    endtask

    // Count edges after the accept edge until done is seen; expect exactly k.
    task automatic wait_done(input string tag, input int k);
        int n;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            n++;
            @(posedge clk_d);
            #1;
            if (done) break;
        end
        chk({tag, "_done_lat"}, n, k);
        @(posedge clk_d);
        #1;
        chk({tag, "_done_1cyc"}, done, 0);
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_ready_after"}, cmd_ready, 1);
    endtask

    task automatic read_cell(input string tag, input int x, input int y, input logic [11:0] exp);
        @(negedge clk_d);
        x_loc = 10'(x);
        y_loc = 10'(y);
        @(posedge clk_d);
        #1 chk(tag, rd_color, exp);
    endtask

    task automatic check_all(input string tag);
        for (int y = 0; y < 10; y++)
            for (int x = 0; x < 10; x++)
                read_cell($sformatf("%s_%0d_%0d", tag, x, y), x, y, model[x][y]);
    endtask

    initial begin
        int cnt;

        // 1: reset state, full-screen fill
        repeat (3) @(posedge clk_d);
        #1;
        chk("rst_rd_color", rd_color, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(negedge clk_d);
        reset = 1'b0;
        #1 chk("rst_ready", cmd_ready, 1);

        send_cmd(0, 0, 9, 9, 12'h801);
        model_fill(0, 0, 9, 9, 12'h801);
        chk("t1_busy", busy, 1);
        chk("t1_ready_low", cmd_ready, 0);
        wait_done("t1", 100);
        check_all("t1");

        // 2: single cell
        send_cmd(3, 4, 3, 4, 12'hFFF);
        model_fill(3, 4, 3, 4, 12'hFFF);
        wait_done("t2", 1);
        read_cell("t2_3_4", 3, 4, 12'hFFF);
        read_cell("t2_2_4", 2, 4, 12'h801);
        read_cell("t2_4_4", 4, 4, 12'h801);
        read_cell("t2_3_3", 3, 3, 12'h801);
        read_cell("t2_3_5", 3, 5, 12'h801);

        // 3: x0 > x1 rejected
        send_cmd(5, 0, 2, 0, 12'h123);
        chk("t3_err", err, 1);
        chk("t3_ready", cmd_ready, 1);
        chk("t3_busy", busy, 0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_d);
            #1;
            if (done || err || busy || !cmd_ready) cnt++;
        end
        chk("t3_quiet", cnt, 0);
        check_all("t3");

        // 4: x1 == COLS rejected; out-of-range reads return zero
        send_cmd(0, 0, 10, 0, 12'hABC);
        chk("t4_err", err, 1);
        @(posedge clk_d);
        #1 chk("t4_err_1cyc", err, 0);
        read_cell("t4_rd_x12", 12, 0, 12'h000);
        read_cell("t4_rd_y10", 0, 10, 12'h000);
        read_cell("t4_rd_9_9", 9, 9, 12'h801);
        read_cell("t4_rd_0_0", 0, 0, 12'h801);

        // 5: second command held while busy, accepted on the first IDLE edge
        send_cmd(0, 0, 1, 1, 12'h0A0);
        model_fill(0, 0, 1, 1, 12'h0A0);
        cmd_x0 = 10'd5; cmd_y0 = 10'd5; cmd_x1 = 10'd6; cmd_y1 = 10'd6;
        cmd_color = 12'h00F;
        cmd_valid = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) break;
            cnt++;
            @(posedge clk_d);
            #1;
        end
        chk("t5_ready_low_cycles", cnt, 5);
        @(posedge clk_d);
        #1 cmd_valid = 1'b0;
        chk("t5_second_accepted", busy, 1);
        model_fill(5, 5, 6, 6, 12'h00F);
        wait_done("t5", 4);
        check_all("t5");

        // 6: reset during a fill leaves the written prefix only
        send_cmd(0, 0, 9, 9, 12'h000);
        model_fill(0, 0, 9, 9, 12'h000);
        wait_done("t6_pre", 100);
        send_cmd(0, 0, 9, 9, 12'h555);
        repeat (25) @(posedge clk_d);
        @(negedge clk_d);
        reset = 1'b1;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_err", err, 0);
        chk("t6_rd_rst", rd_color, 0);
        @(posedge clk_d);
        #1;
        chk("t6_done_post", done, 0);
        @(negedge clk_d);
        reset = 1'b0;
        model_fill(0, 0, 9, 1, 12'h555);
        model_fill(0, 2, 4, 2, 12'h555);
        check_all("t6");
        chk("t6_idle_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
